// File: rtl/atconv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : atconv_pkg
// Description : Shared sizing constants and the frame-sequencer state type
//               for the atrous-convolution memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package atconv_pkg;

  localparam int DW      = 13;    // fixed-point 9.4 word width
  localparam int IMG_PIX = 4096;  // 64x64 image / layer-0 words
  localparam int L1_PIX  = 1024;  // 32x32 layer-1 words
  localparam int IMG_AW  = 12;    // address width for IMG / L0
  localparam int L1_AW   = 10;    // address width for L1
  localparam int CNT_W   = 13;    // frame counters; wide enough for 5120

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DUMP = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/atconv_bank_ram.sv
`default_nettype none
// ============================================================================
// Module      : atconv_bank_ram
// Description : Word-wide storage bank, synchronous write, asynchronous read.
//               Out-of-range read addresses return 0; out-of-range writes
//               are dropped.
// Ports       : clk      - write clock
//               i_we     - write enable
//               i_waddr  - write address
//               i_wdata  - write data
//               i_raddr  - read address (combinational read)
//               o_rdata  - read data
// Revision    : 1.0 - initial release
// ============================================================================
module atconv_bank_ram #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12,
  parameter int DW    = 13
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we && (32'(i_waddr) < DEPTH)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // A read racing a write to the same word sees the pre-write contents.
  assign o_rdata = (32'(i_raddr) < DEPTH) ? r_mem[i_raddr] : '0;

endmodule
`default_nettype wire

// File: rtl/atconv_mem_resp.sv
`default_nettype none
// ============================================================================
// Module      : atconv_mem_resp
// Description : Frame-level memory responder for an atrous-convolution
//               accelerator. Loads an image from the host, pulses ready,
//               serves image / layer memories while the accelerator runs,
//               then streams the layer results back to the host.
//               Build option ATCONV_DUMP_L0_EN: when defined the result
//               stream carries L0 followed by L1; otherwise L1 only and the
//               L0 dump read path is not built.
// Ports       : clk, reset (sync, active-low)
//               ld_valid/ld_ready/ld_data         - host image load stream
//               ready, busy                       - accelerator handshake
//               iaddr/idata                       - image read port
//               cwr/caddr_wr/cdata_wr             - layer write port
//               crd/caddr_rd/cdata_rd, csel       - layer read port, bank sel
//               dout_valid/ready/data/layer/last  - result stream
//               done                              - frame complete pulse
// Revision    : 1.0 - initial release
// ============================================================================
module atconv_mem_resp #(
  parameter int IMG_PIX = atconv_pkg::IMG_PIX,
  parameter int L1_PIX  = atconv_pkg::L1_PIX,
  parameter int DW      = atconv_pkg::DW
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [DW-1:0]               ld_data,
  output logic                        ready,
  input  logic                        busy,
  input  logic [atconv_pkg::IMG_AW-1:0] iaddr,
  output logic [DW-1:0]               idata,
  input  logic                        cwr,
  input  logic [atconv_pkg::IMG_AW-1:0] caddr_wr,
  input  logic [DW-1:0]               cdata_wr,
  input  logic                        crd,
  input  logic [atconv_pkg::IMG_AW-1:0] caddr_rd,
  output logic [DW-1:0]               cdata_rd,
  input  logic                        csel,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic [DW-1:0]               dout_data,
  output logic                        dout_layer,
  output logic                        dout_last,
  output logic                        done
);

  import atconv_pkg::*;

`ifdef ATCONV_DUMP_L0_EN
  localparam int c_DUMP_WORDS = IMG_PIX + L1_PIX;
`else
  localparam int c_DUMP_WORDS = L1_PIX;
`endif
  localparam logic [CNT_W-1:0] c_IMG_LAST  = CNT_W'(IMG_PIX - 1);
  localparam logic [CNT_W-1:0] c_DUMP_END  = CNT_W'(c_DUMP_WORDS);
  localparam logic [CNT_W-1:0] c_DUMP_LAST = CNT_W'(c_DUMP_WORDS - 1);

  state_t               r_state, w_state_next;
  logic [CNT_W-1:0]     r_ld_cnt;
  logic [CNT_W-1:0]     r_dcnt;       // index of the next word to fetch
  logic                 r_busy_q;
  logic                 r_ld_ready, r_ready, r_done;
  logic                 r_dout_valid, r_dout_layer, r_dout_last;
  logic [DW-1:0]        r_dout_data;

  logic                 w_ld_fire, w_dout_fire, w_in_run, w_in_dump;
  logic                 w_l0_we, w_l1_we, w_l1_rd_ok;
  logic [IMG_AW-1:0]    w_l0_raddr;
  logic [L1_AW-1:0]     w_l1_raddr, w_l1_dump_addr;
  logic [DW-1:0]        w_l0_rdata, w_l1_rdata, w_dump_data;
  logic                 w_dump_is_l1;

  assign w_in_run    = (r_state == ST_RUN);
  assign w_in_dump   = (r_state == ST_DUMP);
  assign w_ld_fire   = ld_valid && r_ld_ready && (r_state == ST_LOAD);
  assign w_dout_fire = r_dout_valid && dout_ready;

  // Layer writes only land while the accelerator owns the memories.
  assign w_l0_we    = w_in_run && cwr && !csel;
  assign w_l1_we    = w_in_run && cwr && csel && (caddr_wr < IMG_AW'(L1_PIX));
  assign w_l1_rd_ok = caddr_rd < IMG_AW'(L1_PIX);

`ifdef ATCONV_DUMP_L0_EN
  assign w_dump_is_l1   = (r_dcnt >= CNT_W'(IMG_PIX));
  assign w_l1_dump_addr = L1_AW'(r_dcnt - CNT_W'(IMG_PIX));
  // During DUMP the bank read ports are borrowed by the result stream.
  assign w_l0_raddr     = w_in_dump ? r_dcnt[IMG_AW-1:0] : caddr_rd;
  assign w_dump_data    = w_dump_is_l1 ? w_l1_rdata : w_l0_rdata;
`else
  assign w_dump_is_l1   = 1'b1;
  assign w_l1_dump_addr = r_dcnt[L1_AW-1:0];
  assign w_l0_raddr     = caddr_rd;
  assign w_dump_data    = w_l1_rdata;
`endif
  assign w_l1_raddr = w_in_dump ? w_l1_dump_addr : caddr_rd[L1_AW-1:0];

  atconv_bank_ram #(.DEPTH(IMG_PIX), .AW(IMG_AW), .DW(DW)) u_img (
    .clk(clk), .i_we(w_ld_fire), .i_waddr(r_ld_cnt[IMG_AW-1:0]),
    .i_wdata(ld_data), .i_raddr(iaddr), .o_rdata(idata)
  );

  atconv_bank_ram #(.DEPTH(IMG_PIX), .AW(IMG_AW), .DW(DW)) u_l0 (
    .clk(clk), .i_we(w_l0_we), .i_waddr(caddr_wr),
    .i_wdata(cdata_wr), .i_raddr(w_l0_raddr), .o_rdata(w_l0_rdata)
  );

  atconv_bank_ram #(.DEPTH(L1_PIX), .AW(L1_AW), .DW(DW)) u_l1 (
    .clk(clk), .i_we(w_l1_we), .i_waddr(caddr_wr[L1_AW-1:0]),
    .i_wdata(cdata_wr), .i_raddr(w_l1_raddr), .o_rdata(w_l1_rdata)
  );

  always_comb begin
    cdata_rd = '0;
    if (crd) begin
      if (!csel) begin
        cdata_rd = w_l0_rdata;
      end else if (w_l1_rd_ok) begin
        cdata_rd = w_l1_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_LOAD: if (w_ld_fire && (r_ld_cnt == c_IMG_LAST)) w_state_next = ST_ARM;
      ST_ARM:  w_state_next = ST_RUN;
      // busy_q can only be 1 after busy was seen high in RUN.
      ST_RUN:  if (r_busy_q && !busy) w_state_next = ST_DUMP;
      ST_DUMP: if (w_dout_fire && r_dout_last) w_state_next = ST_LOAD;
      default: w_state_next = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ld_cnt     <= '0;
      r_dcnt       <= '0;
      r_busy_q     <= 1'b0;
      r_ld_ready   <= 1'b0;
      r_ready      <= 1'b0;
      r_done       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_dout_data  <= '0;
      r_dout_layer <= 1'b0;
      r_dout_last  <= 1'b0;
    end else begin
      // Registered from next state so both track the state register exactly.
      r_ld_ready <= (w_state_next == ST_LOAD);
      r_ready    <= (w_state_next == ST_ARM);
      r_done     <= 1'b0;
      r_busy_q   <= w_in_run ? busy : 1'b0;

      if (w_ld_fire) begin
        r_ld_cnt <= (r_ld_cnt == c_IMG_LAST) ? '0 : r_ld_cnt + 1'b1;
      end

      if (w_in_dump) begin
        if (w_dout_fire && r_dout_last) begin
          r_done       <= 1'b1;
          r_dcnt       <= '0;
          r_dout_valid <= 1'b0;
          r_dout_data  <= '0;
          r_dout_layer <= 1'b0;
          r_dout_last  <= 1'b0;
        end else if (!r_dout_valid || dout_ready) begin
          if (r_dcnt < c_DUMP_END) begin
            r_dout_valid <= 1'b1;
            r_dout_data  <= w_dump_data;
            r_dout_layer <= w_dump_is_l1;
            r_dout_last  <= (r_dcnt == c_DUMP_LAST);
            r_dcnt       <= r_dcnt + 1'b1;
          end else begin
            r_dout_valid <= 1'b0;
          end
        end
      end
    end
  end

  assign ld_ready   = r_ld_ready;
  assign ready      = r_ready;
  assign done       = r_done;
  assign dout_valid = r_dout_valid;
  assign dout_data  = r_dout_data;
  assign dout_layer = r_dout_layer;
  assign dout_last  = r_dout_last;

endmodule
`default_nettype wire
